// File: rtl/audio_filt_pkg.sv
// Shared types and elaboration helpers for the multi-channel moving-average filter.
package audio_filt_pkg;

  // Filter control states: CLEAR zeroes the history, RUN processes samples.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } filt_state_t;

  // Tap count N derived from its log2.
  function automatic int taps(input int log2_n);
    return 1 << log2_n;
  endfunction

  // Accumulator width: one guard bit above the sample width.
  function automatic int acc_width(input int data_w);
    return data_w + 1;
  endfunction

  // LSB position of channel ch inside a packed multi-channel word.
  function automatic int ch_lsb(input int ch, input int data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/audio_hist_buf.sv
// History buffer: DEPTH words, each holding the pre-scaled samples of every
// channel. Combinational read at addr, synchronous write or clear at addr.
module audio_hist_buf #(
  parameter int WORD_W = 48,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Clear has priority so the CLEAR sweep always leaves zeros behind.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem[addr] <= '0;
    end else if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// N-tap boxcar noise filter for the codec audio path, with bypass mode.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge, and
// ready may depend combinationally on the partner's valid/ready.
// in_ready is high only in RUN and only when the one-entry output register
// is empty or being drained this cycle, so the filter sustains one sample
// per cycle. Every accept produces exactly one output one cycle later.
//
// Each sample is pre-scaled by >>> LOG2_N before it enters the history, so
// the running sum of N entries is already the average and cannot overflow.
module audio_avg_filter
  import audio_filt_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 2,
  parameter int LOG2_N = 3
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     state_dbg
);

  localparam int N      = taps(LOG2_N);
  localparam int ACC_W  = acc_width(DATA_W);
  localparam int WORD_W = NUM_CH * DATA_W;

  filt_state_t       state, state_next;
  logic [LOG2_N-1:0] clr_cnt;
  logic [LOG2_N-1:0] wr_ptr;
  logic [LOG2_N-1:0] hist_addr;
  logic              mode_q;
  logic              mode_chg;
  logic              slot_free;
  logic              accept;
  logic              hist_we;
  logic              hist_clr;
  logic [WORD_W-1:0] hist_rd;
  logic [WORD_W-1:0] hist_wr;
  logic [WORD_W-1:0] filt_word;

  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign mode_chg  = (state == ST_RUN) && (mode != mode_q);
  assign hist_addr = (state == ST_CLEAR) ? clr_cnt : wr_ptr;
  assign state_dbg = (state == ST_RUN);

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next state, input handshake and history write control.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    hist_we    = 1'b0;
    hist_clr   = 1'b0;
    case (state)
      ST_CLEAR: begin
        hist_clr = 1'b1;
        if (clr_cnt == LOG2_N'(N - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = slot_free;
        hist_we  = in_valid & slot_free;
        if (mode_chg) begin
          state_next = ST_CLEAR;
        end
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // Clear sweep counter, write pointer and mode tracking.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clr_cnt <= '0;
      wr_ptr  <= '0;
      mode_q  <= mode;
    end else begin
      mode_q <= mode;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else begin
        clr_cnt <= '0;
      end
      if ((state == ST_CLEAR) || mode_chg) begin
        wr_ptr <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Per-channel scaling and running-sum update.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [DATA_W-1:0] s;
    logic signed [DATA_W-1:0] old;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    assign s        = $signed(in_data[ch_lsb(k, DATA_W) +: DATA_W]) >>> LOG2_N;
    assign old      = hist_rd[ch_lsb(k, DATA_W) +: DATA_W];
    assign acc_next = acc + {s[DATA_W-1], s} - {old[DATA_W-1], old};

    assign hist_wr[ch_lsb(k, DATA_W) +: DATA_W]   = s;
    assign filt_word[ch_lsb(k, DATA_W) +: DATA_W] = acc_next[DATA_W-1:0];

    // Accumulator tracks the sum of the history; zero whenever history is.
    always_ff @(posedge CLOCK_50) begin
      if (reset || (state == ST_CLEAR) || mode_chg) begin
        acc <= '0;
      end else if (accept) begin
        acc <= acc_next;
      end
    end
  end

  // One-entry output register; reload and drain may coincide.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mode_q ? filt_word : in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  audio_hist_buf #(
    .WORD_W (WORD_W),
    .DEPTH  (N),
    .ADDR_W (LOG2_N)
  ) u_hist (
    .clk     (CLOCK_50),
    .we      (hist_we),
    .clr     (hist_clr),
    .addr    (hist_addr),
    .wr_data (hist_wr),
    .rd_data (hist_rd)
  );

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter: directed stimulus, queue-based reference model
// of the moving average, scoreboard on every output transfer.
module tb_audio_avg_filter;
  import audio_filt_pkg::*;

  localparam int DW     = 24;
  localparam int NCH    = 2;
  localparam int N_TAPS = 8;

  logic          clk;
  logic          reset;
  logic          mode;
  logic [47:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [47:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_q[$];
  int          hist_q[NCH][$];

  audio_avg_filter #(.DATA_W(DW), .NUM_CH(NCH), .LOG2_N(3)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [47:0] pk(input int c0, input int c1);
    logic [23:0] a;
    logic [23:0] b;
    a = c0[23:0];
    b = c1[23:0];
    return {b, a};
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      hist_q[ch].delete();
      for (int i = 0; i < N_TAPS; i++) hist_q[ch].push_back(0);
    end
  endfunction

  // Average of the last N_TAPS floor(x/N) values; bypass returns the input.
  function automatic logic [47:0] model_out(input logic [47:0] d, input logic m);
    logic [47:0] r;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      logic [23:0] raw;
      int x;
      int q;
      int sum;
      raw = d[ch*DW +: DW];
      x   = int'($signed(raw));
      q   = x / N_TAPS;
      if ((x < 0) && (x % N_TAPS != 0)) q = q - 1;
      hist_q[ch].push_back(q);
      void'(hist_q[ch].pop_front());
      sum = 0;
      foreach (hist_q[ch][i]) sum += hist_q[ch][i];
      r[ch*DW +: DW] = sum[23:0];
    end
    return m ? r : d;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic        lat_pend   = 1'b0;
  logic        held_valid = 1'b0;
  logic [47:0] held_data  = '0;
  logic        prev_mode  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_clear();
      lat_pend   = 1'b0;
      held_valid = 1'b0;
      prev_mode  = mode;
    end else begin
      if (lat_pend) check("latency_1cycle", 64'(out_valid), 64'd1);
      lat_pend = 1'b0;
      if (mode != prev_mode) model_clear();
      prev_mode = mode;
      if (held_valid) check("out_hold", 64'(out_data), 64'(held_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'(exp_q.size()), 64'd1);
        end else begin
          check("sb_out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(model_out(in_data, mode));
        lat_pend = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call aligned just after a rising edge. Returns number of cycles waited.
  task automatic send(input logic [47:0] d, output int n);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string name, input logic [47:0] d,
                          input logic [47:0] e, output int n);
    send(d, n);
    @(negedge clk);
    check(name, 64'(out_data), 64'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic m);
    @(posedge clk);
    #1;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset     = 1'b1;
    mode      = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_state",     64'(state_dbg), 64'(ST_CLEAR));
    reset = 1'b0;

    // Warm-up ramp then steady state: ch0 = 800, ch1 = -16.
    for (int i = 0; i < 10; i++) begin
      send_chk("ramp", pk(800, -16),
               pk((i < 8) ? 100 * (i + 1) : 800, (i < 8) ? -2 * (i + 1) : -16), n);
      if (i == 0) check("clear_len_reset", 64'(n), 64'd8);
    end

    // ch1 switches to -1: floor(-1/8) = -1, converges to -8.
    for (int i = 0; i < 8; i++) begin
      send_chk("ch1_converge", pk(800, -1), pk(800, -15 + i), n);
    end

    // Backpressure: hold output for 5 cycles, then drain and accept together.
    out_ready = 1'b0;
    send_chk("bp_first", pk(800, -1), pk(800, -8), n);
    in_data  = pk(1600, -1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_valid_held",   64'(out_valid), 64'd1);
      check("bp_data_held",    64'(out_data), 64'(pk(800, -8)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_data",  64'(out_data), 64'(pk(900, -8)));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_no_dup", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Bypass: mode change forces a fresh CLEAR, then passthrough.
    set_mode(1'b0);
    send_chk("bypass", 48'hABCDEF_123456, 48'hABCDEF_123456, n);
    check("clear_len_bypass", 64'(n), 64'd8);

    // Back to filter mode: history starts from zero again.
    set_mode(1'b1);
    send_chk("refilter", pk(1000, 0), pk(125, 0), n);
    check("clear_len_refilter", 64'(n), 64'd8);
    send_chk("refilter2", pk(1000, 0), pk(250, 0), n);
    send_chk("refilter3", pk(1000, 0), pk(375, 0), n);

    // Reset with a pending output.
    out_ready = 1'b0;
    send(pk(1000, 0), n);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    check("midrst_state",     64'(state_dbg), 64'(ST_CLEAR));
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    send_chk("post_reset", pk(8, -8), pk(1, -1), n);
    check("clear_len_midrst", 64'(n), 64'd8);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_avg_filter.md
Name: audio_avg_filter

Overview:
Parametrised multi-channel moving-average (N-tap boxcar) noise filter. It sits between the audio CODEC read port and write port in the lab3 audio path, replacing the direct passthrough. Ready/valid handshake maps directly onto codec read_ready/read and write_ready/write. Runtime mode input selects filter or bypass; any mode change flushes the history.

Parameters:
DATA_W, 24, sample width per channel, two's complement
NUM_CH, 2, channel count; channel k occupies bits [k*DATA_W +: DATA_W] (ch0 = left)
LOG2_N, 3, log2 of tap count N (N = 8 by default); legal range 1..6

Ports:
CLOCK_50  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
mode  in  1  0 = bypass, 1 = moving-average filter
in_data  in  NUM_CH*DATA_W  packed input samples (codec readdata)
in_valid  in  1  input sample set available (codec read_ready)
in_ready  out  1  block accepts input this cycle (drives codec read)
out_data  out  NUM_CH*DATA_W  packed output samples (codec writedata)
out_valid  out  1  out_data valid (drives codec write, gated by write_ready externally)
out_ready  in  1  downstream accepts output (codec write_ready)

Behaviour:
- Reset (sync, active-high): state=CLEAR, clr_cnt=0, wr_ptr=0, all accumulators=0, out_valid=0, out_data=0, in_ready=0, mode_q=mode.
- States: CLEAR, RUN.
- CLEAR: writes zero to history entry clr_cnt on every channel, clr_cnt++; in_ready=0; after N cycles (clr_cnt==N-1 written) -> RUN. Accumulators held at 0. out_valid unaffected (pending output may still drain).
- RUN: in_ready = ~out_valid | out_ready (one-entry output register; input accepted only when output slot free or emptying this cycle).
- Accept = in_valid & in_ready. Only on accept: per channel s = in >>> LOG2_N (arithmetic, floor toward -inf); old = hist[wr_ptr]; acc_next = acc + s - old; hist[wr_ptr] <= s; acc <= acc_next; wr_ptr <= wr_ptr+1 (wraps N-1 -> 0).
- Output: on accept, out_data <= (mode_q ? acc_next[DATA_W-1:0] : in_data), out_valid <= 1. Latency: exactly 1 cycle from accept to out_valid.
- out_valid clears when out_valid & out_ready & ~accept; simultaneous drain and accept reloads out_data, out_valid stays 1 (full throughput, one sample/cycle).
- out_data stable while out_valid & ~out_ready.
- Accumulator width DATA_W+1 internally; |s| <= 2^(DATA_W-1-LOG2_N), so the sum of N entries always fits DATA_W bits; no saturation logic.
- History updated in bypass too (so filter output is correct only after CLEAR; see mode change).
- Mode change: mode sampled into mode_q each cycle; if mode != mode_q while in RUN -> CLEAR (history and acc zeroed, wr_ptr=0). Pending output remains and drains normally.
- Warm-up: first N-1 filtered outputs after CLEAR ramp (zeros in history); no masking.
- Reset mid-operation overrides everything including a pending output (out_valid drops next cycle).

Decomposition:
- Package audio_filt_pkg: state enum {CLEAR, RUN}, derived localparam N = 1<<LOG2_N, ACC_W = DATA_W+1, helper for per-channel slice indexing.
- Sub-module audio_hist_buf: N x (NUM_CH*DATA_W) register array, async read at wr_ptr, sync write with clear port; instantiated once, all channels packed in one word.
- Top holds FSM, pointer, per-channel accumulators (generate loop over NUM_CH), output register.

Test Plan:
- Reset, then hold in_valid=1 -> in_ready=0 for exactly 8 cycles after reset release, first accept on cycle 9.
- mode=1, ch0 constant 800 (8 accepts, out_ready=1) -> out ch0 = 100,200,...,800, then steady 800; out_valid 1 cycle after each accept.
- mode=1, ch1 constant -16 then -1 -> ramps -2,-4,...,-16; after switching to -1, converges to -8 (floor: -1>>>3 = -1) after 8 samples; ch0 independent.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data held for 5 cycles; out_ready=1 with in_valid=1 -> drain and accept same cycle, no sample lost or duplicated.
- mode=0 feeding 0x123456 -> out_data=0x123456 one cycle later; toggle mode to 1 -> 8 CLEAR cycles with in_ready=0, next output after 1000 input = 125.
- Assert reset mid-stream with out_valid=1 -> next cycle out_valid=0, out_data=0, state CLEAR, prior history not reflected in subsequent outputs.
